// File: rtl/icache_dm_if.sv
// icache_dm bus bundle: CPU fetch port plus the word-wise refill port.
// The slave side is the cache, the master side drives fetches and memory.
interface icache_dm_if;
  logic [31:0] i_addr;
  logic [31:0] o_data;
  logic        o_valid;
  logic        i_flush;
  logic [31:0] o_mem_addr;
  logic        o_mem_rd;
  logic [31:0] i_mem_data;
  logic        i_mem_valid;

  modport master (
    output i_addr, i_flush, i_mem_data, i_mem_valid,
    input  o_data, o_valid, o_mem_addr, o_mem_rd
  );

  modport slave (
    input  i_addr, i_flush, i_mem_data, i_mem_valid,
    output o_data, o_valid, o_mem_addr, o_mem_rd
  );
endinterface

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache.
// Zero-latency hits, whole-line refill over a word-wise read port.
module icache_dm #(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64
) (
  input logic        i_clk,
  input logic        i_rst,
  icache_dm_if.slave bus
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int LW = $clog2(LINES);
  localparam int TW = 32 - OW - LW - 2;
  localparam int BW = TW + LW;
  localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]   tag_q  [LINES];
  logic [31:0]     data_q [LINES*LINE_WORDS];
  logic [BW-1:0]   base_q;
  logic [OW-1:0]   cnt_q;
  logic            fpend_q;

  logic [TW-1:0] a_tag;
  logic [LW-1:0] a_idx;
  logic [OW-1:0] a_word;
  logic [LW-1:0] r_idx;
  logic          hit;
  logic          beat;
  logic          last;
  logic          unused_lsb;

  assign a_tag      = bus.i_addr[31:OW+LW+2];
  assign a_idx      = bus.i_addr[OW+LW+1:OW+2];
  assign a_word     = bus.i_addr[OW+1:2];
  assign unused_lsb = ^bus.i_addr[1:0];
  assign r_idx      = base_q[LW-1:0];
  assign hit        = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign beat       = (state_q == REFILL) && bus.i_mem_valid;
  assign last       = beat && (cnt_q == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.o_valid    = 1'b0;
    bus.o_data     = '0;
    bus.o_mem_rd   = 1'b0;
    bus.o_mem_addr = '0;
    unique case (state_q)
      IDLE: begin
        if (!hit && !bus.i_flush) state_d = REFILL;
        if (hit && !i_rst && !bus.i_flush) begin
          bus.o_valid = 1'b1;
          bus.o_data  = data_q[{a_idx, a_word}];
        end
      end
      REFILL: begin
        if (last) state_d = IDLE;
        if (!i_rst) begin
          bus.o_mem_rd   = 1'b1;
          bus.o_mem_addr = {base_q, cnt_q, 2'b00};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      fpend_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_flush) begin
            valid_q <= '0;
          end else if (!hit) begin
            base_q         <= {a_tag, a_idx};
            valid_q[a_idx] <= 1'b0;
            cnt_q          <= '0;
          end
        end
        REFILL: begin
          if (beat) cnt_q <= cnt_q + OW'(1);
          if (bus.i_flush) fpend_q <= 1'b1;
          // a flush seen at any point of the refill leaves the cache empty
          if (last) begin
            fpend_q <= 1'b0;
            if (fpend_q || bus.i_flush) valid_q <= '0;
            else                        valid_q[r_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && beat) begin
      data_q[{r_idx, cnt_q}] <= bus.i_mem_data;
      if (cnt_q == LAST) tag_q[r_idx] <= base_q[BW-1:LW];
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed plus random fetch traffic against a
// line-granular model of a direct-mapped cache over a fixed memory.
module tb_icache_dm;
  localparam int NW = 4;
  localparam int NL = 64;

  logic clk = 1'b0;
  logic rst;
  icache_dm_if bus ();

  icache_dm #(.LINE_WORDS(NW), .LINES(NL)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 0;

  bit          mvalid [NL];
  logic [21:0] mtag   [NL];
  bit          busy;
  bit          fpend;
  logic [31:0] lbase;
  int          got;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a >> 2) ^ 32'hC0DE0000;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[9:4]);
  endfunction

  function automatic bit mhit(input logic [31:0] a);
    return mvalid[idx_of(a)] && (mtag[idx_of(a)] == a[31:10]);
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NL; i++) mvalid[i] = 0;
  endtask

  // model: memory is fixed, so a valid line always mirrors memf
  always @(posedge clk) begin
    if (rst) begin
      busy  = 0;
      fpend = 0;
      clear_all();
    end else if (!busy) begin
      if (bus.i_flush) begin
        clear_all();
      end else if (!mhit(bus.i_addr)) begin
        busy  = 1;
        lbase = {bus.i_addr[31:4], 4'h0};
        got   = 0;
        mvalid[idx_of(bus.i_addr)] = 0;
      end
    end else begin
      if (bus.i_flush) fpend = 1;
      if (bus.i_mem_valid) begin
        got++;
        if (got == NW) begin
          busy = 0;
          if (fpend) begin
            clear_all();
          end else begin
            mvalid[idx_of(lbase)] = 1;
            mtag[idx_of(lbase)]   = lbase[31:10];
          end
          fpend = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic        e_rd, e_v;
    logic [31:0] e_ma, e_d;
    if (cmp_en) begin
      e_rd = busy && !rst;
      e_ma = e_rd ? lbase + 32'(4 * got) : 32'h0;
      e_v  = !busy && !rst && !bus.i_flush && mhit(bus.i_addr);
      e_d  = e_v ? memf(bus.i_addr) : 32'h0;
      chk("o_mem_rd", 32'(bus.o_mem_rd), 32'(e_rd));
      chk("o_mem_addr", bus.o_mem_addr, e_ma);
      chk("o_valid", 32'(bus.o_valid), 32'(e_v));
      chk("o_data", bus.o_data, e_d);
    end
  end

  task automatic step(input logic [31:0] a, input bit fl,
                      input bit r, input bit mv);
    @(posedge clk);
    #1;
    bus.i_addr      = a;
    bus.i_flush     = fl;
    rst             = r;
    bus.i_mem_valid = mv;
    #1;
    bus.i_mem_data = bus.o_mem_rd ? memf(bus.o_mem_addr) : $urandom;
  endtask

  task automatic drain(input logic [31:0] a);
    int n = 0;
    do begin
      step(a, 0, 0, 1'($urandom_range(0, 1)));
      n++;
    end while (busy && n < 100);
    chk("drain_bound", 32'(n < 100), 32'h1);
  endtask

  initial begin
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    rst             = 1'b1;
    bus.i_addr      = 32'h0;
    bus.i_flush     = 1'b0;
    bus.i_mem_valid = 1'b0;
    bus.i_mem_data  = 32'h0;
    for (int i = 0; i < NL; i++) begin
      mvalid[i] = 0;
      mtag[i]   = '0;
    end
    busy  = 0;
    fpend = 0;
    got   = 0;
    lbase = 32'h0;

    step(32'h100, 0, 1, 1);
    cmp_en = 1;
    step(32'h100, 0, 1, 1);
    chk("rst_rd", 32'(bus.o_mem_rd), 32'h0);
    chk("rst_ma", bus.o_mem_addr, 32'h0);
    chk("rst_v", 32'(bus.o_valid), 32'h0);
    chk("rst_d", bus.o_data, 32'h0);

    // cold miss, no gaps
    step(32'h100, 0, 0, 0);
    chk("cold_idle_rd", 32'(bus.o_mem_rd), 32'h0);
    step(32'h100, 0, 0, 1);
    chk("cold_ma0", bus.o_mem_addr, 32'h100);
    step(32'h100, 0, 0, 1);
    step(32'h100, 0, 0, 1);
    step(32'h100, 0, 0, 1);
    chk("cold_ma3", bus.o_mem_addr, 32'h10C);
    step(32'h100, 0, 0, 0);
    chk("cold_v", 32'(bus.o_valid), 32'h1);
    chk("cold_d", bus.o_data, 32'hC0DE0040);
    step(32'h10C, 0, 0, 0);
    chk("hit_d3", bus.o_data, 32'hC0DE0043);

    // gapped refill
    step(32'h200, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(32'h200, 0, 0, pat[i]);
      if (i == 2) chk("gap_hold", bus.o_mem_addr, 32'h204);
      if (i == 6) chk("gap_last", bus.o_mem_addr, 32'h20C);
    end
    step(32'h200, 0, 0, 0);
    chk("gap_v", 32'(bus.o_valid), 32'h1);
    chk("gap_d", bus.o_data, 32'hC0DE0080);

    // conflict on the same index
    step(32'h500, 0, 0, 0);
    chk("conf_miss", 32'(bus.o_valid), 32'h0);
    step(32'h500, 0, 0, 1);
    chk("conf_ma", bus.o_mem_addr, 32'h500);
    step(32'h500, 0, 0, 1);
    step(32'h500, 0, 0, 1);
    step(32'h500, 0, 0, 1);
    step(32'h504, 0, 0, 0);
    chk("conf_d", bus.o_data, 32'hC0DE0141);
    step(32'h100, 0, 0, 0);
    chk("conf_evict", 32'(bus.o_valid), 32'h0);
    drain(32'h100);

    // flush in idle
    step(32'h200, 1, 0, 0);
    chk("fl_idle_v", 32'(bus.o_valid), 32'h0);
    step(32'h200, 0, 0, 0);
    chk("fl_miss200", 32'(bus.o_valid), 32'h0);
    drain(32'h200);
    step(32'h100, 0, 0, 0);
    chk("fl_miss100", 32'(bus.o_valid), 32'h0);
    drain(32'h100);

    // flush during refill
    step(32'h300, 0, 0, 0);
    step(32'h300, 0, 0, 1);
    step(32'h300, 0, 0, 1);
    step(32'h300, 1, 0, 1);
    step(32'h300, 0, 0, 1);
    step(32'h300, 0, 0, 0);
    chk("flr_v", 32'(bus.o_valid), 32'h0);
    chk("flr_rd0", 32'(bus.o_mem_rd), 32'h0);
    step(32'h300, 0, 0, 1);
    chk("flr_rd1", 32'(bus.o_mem_rd), 32'h1);
    chk("flr_ma", bus.o_mem_addr, 32'h300);
    drain(32'h300);

    // reset during refill
    step(32'h700, 0, 0, 0);
    step(32'h700, 0, 0, 1);
    step(32'h700, 0, 1, 1);
    chk("rr_rd", 32'(bus.o_mem_rd), 32'h0);
    step(32'h700, 0, 0, 1);
    chk("rr_idle", 32'(bus.o_mem_rd), 32'h0);
    step(32'h700, 0, 0, 1);
    chk("rr_restart", bus.o_mem_addr, 32'h700);
    drain(32'h700);
    step(32'h100, 0, 0, 0);
    chk("rr_miss100", 32'(bus.o_valid), 32'h0);
    drain(32'h100);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] a;
      if ($urandom_range(0, 19) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 3) << 10) |
               32'($urandom_range(0, 7) << 4) |
               32'($urandom_range(0, 15));
      step(a, $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 9) < 6);
    end

    step(32'h0, 0, 0, 0);
    cmp_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
